// File: rtl/arcade_input_pkg.sv
// Shared scancodes, joystick bit positions and coin shaper states for the arcade input path.
// Pure declarations; no timing or flow control.
package arcade_input_pkg;

    // Arrow keys are matched on the low 8 bits so both E0 and keypad variants work
    localparam logic [7:0] SC_UP       = 8'h75;
    localparam logic [7:0] SC_DOWN     = 8'h72;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;

    localparam logic [8:0] SC_SPACE    = 9'h029;
    localparam logic [8:0] SC_CTRL     = 9'h014;
    localparam logic [8:0] SC_F1       = 9'h005;
    localparam logic [8:0] SC_KEY1     = 9'h016;
    localparam logic [8:0] SC_F2       = 9'h006;
    localparam logic [8:0] SC_KEY2     = 9'h01E;
    localparam logic [8:0] SC_COIN1    = 9'h02E;
    localparam logic [8:0] SC_COIN2    = 9'h036;
    localparam logic [8:0] SC_P2_UP    = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT  = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT = 9'h034;
    localparam logic [8:0] SC_P2_FIRE  = 9'h01C;
    localparam logic [8:0] SC_TEST     = 9'h02C;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        WAIT_REL
    } coin_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic space;
        logic ctrl;
        logic f1;
        logic key1;
        logic f2;
        logic key2;
        logic coin1;
        logic coin2;
        logic p2_up;
        logic p2_down;
        logic p2_left;
        logic p2_right;
        logic p2_fire;
        logic test;
    } key_state_t;

    typedef struct packed {
        logic start;
        logic fire;
        logic left;
        logic right;
        logic up;
        logic down;
    } player_t;

    // Horz cabinet: the monitor is turned, so each direction takes its neighbour's source
    function automatic player_t rotate_player(input player_t p, input logic rot);
        player_t r;
        r = p;
        if (rot) begin
            r.up    = p.left;
            r.down  = p.right;
            r.left  = p.down;
            r.right = p.up;
        end
        return r;
    endfunction

    function automatic logic [6:0] pack_ip(input player_t p);
        return ~{p.start, p.fire, p.fire, p.left, p.right, p.up, p.down};
    endfunction

endpackage

// File: rtl/coin_pulse_shaper.sv
// Turns a coin request level into one fixed-length pulse followed by an enforced quiet gap.
// Latency: pulse starts the cycle after a request rising edge; no backpressure, extra requests dropped.
module coin_pulse_shaper
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE = 2_400_000,
    parameter int COIN_GAP   = 2_400_000
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic req,
    output logic coin
);

    localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP - 1);

    coin_state_e      state;
    coin_state_e      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             req_q;
    logic             req_rise;
    logic             cnt_zero;

    assign req_rise = req & ~req_q;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            req_q <= req;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_zero ? cnt : cnt - CNT_W'(1);
        case (state)
            IDLE: begin
                if (req_rise) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_nxt = req ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign coin = (state == PULSE);

endmodule

// File: rtl/arcade_input_mapper.sv
// Maps hps_io PS/2 key events and joysticks onto active-low cabinet inputs with coin pulse shaping.
// Latency: keys 2 cycles, joystick/test 1 cycle, coin 2 cycles after request; no backpressure.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE    = 2_400_000,
    parameter int COIN_GAP      = 2_400_000,
    parameter bit START_IS_COIN = 1'b1
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    input  logic        test_sw,
    output logic [6:0]  ip_1p,
    output logic [6:0]  ip_2p,
    output logic        ip_coin1,
    output logic        ip_coin2,
    output logic        ip_service
);

    logic        old_tog;
    logic        armed;
    logic        key_vld;
    logic        key_pressed;
    logic [8:0]  key_code;
    key_state_t  keys;
    key_state_t  keys_nxt;
    logic [15:0] joy;
    player_t     p1_src;
    player_t     p2_src;
    logic        coin1_req;
    logic        coin2_req;
    logic        coin1_req_r;
    logic        coin2_req_r;
    logic        joy_unused;

    // armed stays low for the first cycle so the reset value of old_tog can't fake an event
    assign key_vld     = armed & (ps2_key[10] != old_tog);
    assign key_pressed = ps2_key[9];
    assign key_code    = ps2_key[8:0];

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            old_tog <= 1'b0;
            armed   <= 1'b0;
            keys    <= '0;
        end else begin
            old_tog <= ps2_key[10];
            armed   <= 1'b1;
            keys    <= keys_nxt;
        end
    end

    always_comb begin
        keys_nxt = keys;
        if (key_vld) begin
            case (key_code[7:0])
                SC_UP:    keys_nxt.up    = key_pressed;
                SC_DOWN:  keys_nxt.down  = key_pressed;
                SC_LEFT:  keys_nxt.left  = key_pressed;
                SC_RIGHT: keys_nxt.right = key_pressed;
                default: ;
            endcase
            // Full 9-bit match rejects E0-prefixed codes for the remaining keys
            case (key_code)
                SC_SPACE:    keys_nxt.space    = key_pressed;
                SC_CTRL:     keys_nxt.ctrl     = key_pressed;
                SC_F1:       keys_nxt.f1       = key_pressed;
                SC_KEY1:     keys_nxt.key1     = key_pressed;
                SC_F2:       keys_nxt.f2       = key_pressed;
                SC_KEY2:     keys_nxt.key2     = key_pressed;
                SC_COIN1:    keys_nxt.coin1    = key_pressed;
                SC_COIN2:    keys_nxt.coin2    = key_pressed;
                SC_P2_UP:    keys_nxt.p2_up    = key_pressed;
                SC_P2_DOWN:  keys_nxt.p2_down  = key_pressed;
                SC_P2_LEFT:  keys_nxt.p2_left  = key_pressed;
                SC_P2_RIGHT: keys_nxt.p2_right = key_pressed;
                SC_P2_FIRE:  keys_nxt.p2_fire  = key_pressed;
                SC_TEST:     keys_nxt.test     = key_pressed;
                default: ;
            endcase
        end
    end

    assign joy        = joystick_0 | joystick_1;
    assign joy_unused = ^joy[15:7];

    always_comb begin
        p1_src.up    = keys.up    | joy[JOY_UP];
        p1_src.down  = keys.down  | joy[JOY_DOWN];
        p1_src.left  = keys.left  | joy[JOY_LEFT];
        p1_src.right = keys.right | joy[JOY_RIGHT];
        p1_src.fire  = keys.space | keys.ctrl | joy[JOY_FIRE];
        p1_src.start = keys.f1 | keys.key1 | joy[JOY_START1];

        p2_src.up    = keys.p2_up    | joy[JOY_UP];
        p2_src.down  = keys.p2_down  | joy[JOY_DOWN];
        p2_src.left  = keys.p2_left  | joy[JOY_LEFT];
        p2_src.right = keys.p2_right | joy[JOY_RIGHT];
        p2_src.fire  = keys.p2_fire  | joy[JOY_FIRE];
        p2_src.start = keys.f2 | keys.key2 | joy[JOY_START2];
    end

    assign coin1_req = keys.coin1 | (START_IS_COIN & (p1_src.start | p2_src.start));
    assign coin2_req = keys.coin2;

    // The request register aligns coin timing with the player output stage
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            ip_1p       <= 7'h7F;
            ip_2p       <= 7'h7F;
            ip_service  <= 1'b1;
            coin1_req_r <= 1'b0;
            coin2_req_r <= 1'b0;
        end else begin
            ip_1p       <= pack_ip(rotate_player(p1_src, rotate));
            ip_2p       <= pack_ip(rotate_player(p2_src, rotate));
            ip_service  <= ~(test_sw | keys.test);
            coin1_req_r <= coin1_req;
            coin2_req_r <= coin2_req;
        end
    end

    coin_pulse_shaper #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP)
    ) u_coin1 (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .req     (coin1_req_r),
        .coin    (ip_coin1)
    );

    coin_pulse_shaper #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP)
    ) u_coin2 (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .req     (coin2_req_r),
        .coin    (ip_coin2)
    );

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomized scoreboard bench for arcade_input_mapper against a per-scancode held-key reference model.
module tb_arcade_input_mapper;

    localparam int P = 4;
    localparam int G = 3;

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        rotate;
    logic        test_sw;
    logic [6:0]  ip_1p;
    logic [6:0]  ip_2p;
    logic        ip_coin1;
    logic        ip_coin2;
    logic        ip_service;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .COIN_PULSE    (P),
        .COIN_GAP      (G),
        .START_IS_COIN (1'b1)
    ) dut (
        .clk_sys    (clk_sys),
        .RESET_N    (RESET_N),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .rotate     (rotate),
        .test_sw    (test_sw),
        .ip_1p      (ip_1p),
        .ip_2p      (ip_2p),
        .ip_coin1   (ip_coin1),
        .ip_coin2   (ip_coin2),
        .ip_service (ip_service)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [16:0] exp_q[$];
    bit          mon_en = 1'b0;
    bit          done = 1'b0;

    // Reference model: one held flag per scancode, pulse start cycles per coin
    bit          held[512];
    int          cyc;
    bit          prev_tog;
    bit          rq1_prev;
    bit          rq2_prev;
    int          start1_at;
    int          start2_at;

    // Current stimulus
    bit          tog;
    logic [10:0] cur_pk;
    logic [15:0] cur_j0;
    logic [15:0] cur_j1;
    bit          cur_rot;
    bit          cur_tsw;
    logic [8:0]  codes[26];

    function automatic int key_slot(input logic [8:0] code);
        if (code[7:0] inside {8'h75, 8'h72, 8'h6B, 8'h74}) return int'(code[7:0]);
        return int'(code);
    endfunction

    function automatic bit coin_on(input int s, input int d);
        return (d >= s) && (d < s + P);
    endfunction

    function automatic logic [16:0] model_out(input logic [15:0] j, input bit rot, input bit tsw,
                                              input bit c1, input bit c2);
        bit u1, d1, l1, r1, f1, s1, u2, d2, l2, r2, f2, s2;
        logic [6:0] a1, a2;
        u1 = held[9'h075] | j[3];
        d1 = held[9'h072] | j[2];
        l1 = held[9'h06B] | j[1];
        r1 = held[9'h074] | j[0];
        f1 = held[9'h029] | held[9'h014] | j[4];
        s1 = held[9'h005] | held[9'h016] | j[5];
        u2 = held[9'h02D] | j[3];
        d2 = held[9'h02B] | j[2];
        l2 = held[9'h023] | j[1];
        r2 = held[9'h034] | j[0];
        f2 = held[9'h01C] | j[4];
        s2 = held[9'h006] | held[9'h01E] | j[6];
        a1 = rot ? {s1, f1, f1, d1, u1, l1, r1} : {s1, f1, f1, l1, r1, u1, d1};
        a2 = rot ? {s2, f2, f2, d2, u2, l2, r2} : {s2, f2, f2, l2, r2, u2, d2};
        return {~a1, ~a2, c1, c2, ~(tsw | held[9'h02C])};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s @%0t: got %05h expected %05h", name, $time, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue the output expected in the following cycle
    task automatic tick();
        logic [15:0] j;
        bit rq1, rq2;
        ps2_key    = cur_pk;
        joystick_0 = cur_j0;
        joystick_1 = cur_j1;
        rotate     = cur_rot;
        test_sw    = cur_tsw;
        j   = cur_j0 | cur_j1;
        rq1 = held[9'h02E] | held[9'h005] | held[9'h016] | held[9'h006] | held[9'h01E] | j[5] | j[6];
        rq2 = held[9'h036];
        if (rq1 && !rq1_prev && (cyc + 2 >= start1_at + P + G + 1)) start1_at = cyc + 2;
        if (rq2 && !rq2_prev && (cyc + 2 >= start2_at + P + G + 1)) start2_at = cyc + 2;
        rq1_prev = rq1;
        rq2_prev = rq2;
        exp_q.push_back(model_out(j, cur_rot, cur_tsw, coin_on(start1_at, cyc + 1), coin_on(start2_at, cyc + 1)));
        if (cyc >= 1 && cur_pk[10] != prev_tog) held[key_slot(cur_pk[8:0])] = cur_pk[9];
        prev_tog = cur_pk[10];
        cyc++;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic key_ev(input bit pressed, input logic [8:0] code);
        tog    = ~tog;
        cur_pk = {tog, pressed, code};
        tick();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        mon_en  = 1'b0;
        RESET_N = 1'b0;
        tog     = 1'b1;
        cur_pk  = {1'b1, 1'b1, 9'h175};
        cur_j0  = '0;
        cur_j1  = '0;
        cur_rot = 1'b0;
        cur_tsw = 1'b0;
        ps2_key = cur_pk;
        joystick_0 = '0;
        joystick_1 = '0;
        rotate  = 1'b0;
        test_sw = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        exp_q.delete();
        foreach (held[i]) held[i] = 1'b0;
        cyc       = 0;
        prev_tog  = cur_pk[10];
        rq1_prev  = 1'b0;
        rq2_prev  = 1'b0;
        start1_at = -1000;
        start2_at = -1000;
        RESET_N   = 1'b1;
        exp_q.push_back({7'h7F, 7'h7F, 1'b0, 1'b0, 1'b1});
        mon_en    = 1'b1;
    endtask

    initial begin
        codes = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074, 9'h174,
                  9'h029, 9'h014, 9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036,
                  9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h02C, 9'h12E, 9'h129,
                  9'h033, 9'h15A};
        fork
            begin : monitor
                logic [16:0] e;
                logic [16:0] a;
                while (!done) begin
                    @(negedge clk_sys);
                    if (mon_en) begin
                        a = {ip_1p, ip_2p, ip_coin1, ip_coin2, ip_service};
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL scoreboard_underrun @%0t: got %05h expected queued entry", $time, a);
                        end else begin
                            e = exp_q.pop_front();
                            check("outputs", a, e);
                        end
                    end
                end
            end
            begin : stimulus
                // Phantom key guard: pressed-up code sits on the bus through reset
                apply_reset();
                ticks(100);

                key_ev(1'b1, 9'h175); ticks(3);
                key_ev(1'b0, 9'h075); ticks(3);

                cur_rot = 1'b1; cur_j0 = 16'h0002; ticks(3);
                cur_j0 = 16'h0000; cur_rot = 1'b0; ticks(2);

                key_ev(1'b1, 9'h02E); ticks(50);
                key_ev(1'b0, 9'h02E); tick();
                key_ev(1'b1, 9'h02E); ticks(12);
                key_ev(1'b0, 9'h02E); ticks(10);

                cur_j0 = 16'h0008;
                key_ev(1'b1, 9'h175); tick();
                key_ev(1'b0, 9'h175); ticks(3);
                cur_j0 = 16'h0000; ticks(2);

                cur_j1 = 16'h0020;
                key_ev(1'b1, 9'h02E); ticks(15);
                cur_j1 = 16'h0000;
                key_ev(1'b0, 9'h02E); ticks(10);

                cur_tsw = 1'b1; ticks(2); cur_tsw = 1'b0;
                key_ev(1'b1, 9'h02C); ticks(3);
                key_ev(1'b0, 9'h02C); ticks(15);

                // Reset landing on the second cycle of a coin pulse
                key_ev(1'b1, 9'h02E); ticks(3);
                check("coin_before_reset", {16'h0, ip_coin1}, {16'h0, coin_on(start1_at, cyc)});
                mon_en = 1'b0;
                #1 RESET_N = 1'b0;
                #1 check("coin_async_reset", {16'h0, ip_coin1}, 17'h0);
                apply_reset();
                ticks(20);
                key_ev(1'b1, 9'h02E); ticks(8);
                key_ev(1'b0, 9'h02E); ticks(8);

                for (int i = 0; i < 2000; i++) begin
                    if ($urandom_range(0, 15) == 0) cur_j0 = 16'($urandom);
                    if ($urandom_range(0, 31) == 0) cur_j1 = 16'($urandom) & 16'hFF9F;
                    if ($urandom_range(0, 63) == 0) cur_rot = ~cur_rot;
                    if ($urandom_range(0, 47) == 0) cur_tsw = ~cur_tsw;
                    if ($urandom_range(0, 3) == 0)
                        key_ev(1'($urandom_range(0, 1)), codes[$urandom_range(0, 25)]);
                    else
                        tick();
                end
                done = 1'b1;
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
